mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_pkg.sv | 27 ++
 rtl/muldiv_step.sv | 37 +++
 rtl/mul_div_unit.sv | 180 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit and the ALU control decoder:
// operation encodings, FSM state encodings and the iteration count.
package mul_div_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam int unsigned ITER_COUNT = 32;
  localparam int unsigned CNT_W      = 6;

  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath. The unit keeps a 64-bit
// working pair {acc, mq}; multiply does shift-add (right shift), divide does
// restoring shift-subtract (left shift, quotient bit enters at mq[0]).
module muldiv_step (
  input  logic        is_div_i,
  input  logic [31:0] acc_i,
  input  logic [31:0] mq_i,
  input  logic [31:0] opnd_i,
  output logic [31:0] acc_o,
  output logic [31:0] mq_o
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic [32:0] diff;

  // Combinational single-step update of the working pair
  always_comb begin
    sum     = {1'b0, acc_i} + (mq_i[0] ? {1'b0, opnd_i} : '0);
    shifted = {acc_i, mq_i[31]};
    diff    = shifted - {1'b0, opnd_i};
    if (is_div_i) begin
      // shifted < 2*divisor, so a borrow shows up as diff[32]
      if (!diff[32]) begin
        acc_o = diff[31:0];
        mq_o  = {mq_i[30:0], 1'b1};
      end else begin
        acc_o = shifted[31:0];
        mq_o  = {mq_i[30:0], 1'b0};
      end
    end else begin
      acc_o = sum[32:1];
      mq_o  = {sum[0], mq_i[31:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO architectural registers.
// IDLE latches magnitudes, CALC runs 32 iterations, FIX spends one cycle
// applying sign correction and one cycle committing HI/LO with a done pulse.
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        DZ,
  output logic        OF
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      mq_q, mq_d;
  logic [31:0]      opnd_q, opnd_d;
  op_e              op_q, op_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic             of_q, of_d;

  op_e         op_in;
  logic        in_signed;
  logic        accept;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [31:0] step_acc;
  logic [31:0] step_mq;
  logic [63:0] prod_neg;

  assign op_in     = op_e'(op);
  assign in_signed = op_is_signed(op_in);
  // The done cycle is IDLE but a start there is dropped, so completions never
  // chain without a gap cycle.
  assign accept    = (state_q == S_IDLE) && start && !done_q;
  assign a_abs     = (in_signed && A[31]) ? -A : A;
  assign b_abs     = (in_signed && B[31]) ? -B : B;
  assign prod_neg  = -{acc_q, mq_q};

  muldiv_step u_step (
    .is_div_i (op_is_div(op_q)),
    .acc_i    (acc_q),
    .mq_i     (mq_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc),
    .mq_o     (step_mq)
  );

  // Next-state logic for the FSM, working registers and HI/LO
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    ovf_d   = ovf_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    of_d    = of_q;
    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (accept) begin
          if (op_is_div(op_in) && (B == '0)) begin
            done_d = 1'b1;
            dz_d   = 1'b1;
            of_d   = 1'b0;
          end else begin
            state_d = S_CALC;
            cnt_d   = '0;
            acc_d   = '0;
            mq_d    = a_abs;
            opnd_d  = b_abs;
            op_d    = op_in;
            a_neg_d = in_signed && A[31];
            b_neg_d = in_signed && B[31];
            ovf_d   = (op_in == OP_DIV) && (A == 32'h8000_0000) && (B == '1);
          end
        end
      end
      S_CALC: begin
        acc_d = step_acc;
        mq_d  = step_mq;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER_COUNT - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        // The counter continues past ITER_COUNT to split FIX into a
        // sign-correction cycle and a commit cycle.
        if (cnt_q == CNT_W'(ITER_COUNT)) begin
          cnt_d = cnt_q + 1'b1;
          if (!op_is_div(op_q)) begin
            if (a_neg_q ^ b_neg_q) {acc_d, mq_d} = prod_neg;
          end else begin
            if (a_neg_q ^ b_neg_q) mq_d = -mq_q;
            if (a_neg_q) acc_d = -acc_q;
          end
        end else begin
          hi_d    = acc_q;
          lo_d    = mq_q;
          done_d  = 1'b1;
          dz_d    = 1'b0;
          of_d    = ovf_q;
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      opnd_q  <= '0;
      op_q    <= OP_MULT;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      ovf_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      ovf_q   <= ovf_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      of_q    <= of_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign DZ   = dz_q;
  assign OF   = of_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit with hand-computed expected values.
module tb_mul_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        DZ;
  logic        OF;

  int n_tests;
  int n_fail;
  int lat;
  logic saw_done;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  mul_div_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done),
    .DZ    (DZ),
    .OF    (OF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one sampling edge; returns #1 after that edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Edges counted from the current point until done is seen; -1 on timeout.
  task automatic wait_done(input int max, output int cycles);
    cycles = -1;
    if (done) begin
      cycles = 0;
      return;
    end
    for (int i = 1; i <= max; i++) begin
      tick();
      if (done) begin
        cycles = i;
        return;
      end
    end
  endtask

  task automatic watch_no_done(input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; op = MULT; A = '0; B = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    tick(); tick();
    rst = 1'b0;

    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", DZ, 0);
    check("rst_of", OF, 0);

    // MULTU max*max, latency and single-cycle done
    tick();
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_busy", busy, 1);
    wait_done(60, lat);
    check("multu_lat", lat, 34);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    check("multu_dz", DZ, 0);
    check("multu_of", OF, 0);
    tick();
    check("multu_done_1cyc", done, 0);
    check("multu_idle", busy, 0);

    // MULT -3*7, operands changed right after sampling
    tick();
    issue(MULT, 32'hFFFF_FFFD, 32'd7);
    op = DIVU; A = 32'd0; B = 32'd0;
    wait_done(60, lat);
    check("mult_lat", lat, 34);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);

    // DIV -7/2
    tick();
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(60, lat);
    check("div_lat", lat, 34);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_of", OF, 0);

    // MTHI/MTLO preload, then DIVU by zero
    tick();
    hi_we = 1'b1; wdata = 32'h11; tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22; tick();
    lo_we = 1'b0;
    check("mthi", hi, 32'h11);
    check("mtlo", lo, 32'h22);
    issue(DIVU, 32'd100, 32'd0);
    wait_done(5, lat);
    check("dz_lat", lat, 0);
    check("dz_flag", DZ, 1);
    check("dz_of", OF, 0);
    check("dz_hi", hi, 32'h11);
    check("dz_lo", lo, 32'h22);
    check("dz_busy", busy, 0);

    // start together with MTHI in IDLE: write lands, completion overwrites
    tick();
    hi_we = 1'b1; wdata = 32'h55;
    issue(MULTU, 32'd2, 32'd3);
    hi_we = 1'b0;
    check("wr_start_hi", hi, 32'h55);
    check("wr_start_busy", busy, 1);
    wait_done(60, lat);
    check("wr_start_lat", lat, 34);
    check("wr_start_rhi", hi, 0);
    check("wr_start_rlo", lo, 6);
    check("wr_start_dz", DZ, 0);

    // Signed overflow
    tick();
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(60, lat);
    check("ovf_lat", lat, 34);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 0);
    check("ovf_of", OF, 1);
    check("ovf_dz", DZ, 0);

    // Back-to-back: start in the done cycle is ignored, one later accepted
    op = DIVU; A = 32'd100; B = 32'd7; start = 1'b1;
    tick();
    check("b2b_ignored", busy, 0);
    check("b2b_of_hold", OF, 1);
    tick();
    start = 1'b0;
    check("b2b_accepted", busy, 1);
    wait_done(60, lat);
    check("b2b_lat", lat, 34);
    check("b2b_lo", lo, 14);
    check("b2b_hi", hi, 2);
    check("b2b_of", OF, 0);

    // Reset during FIX aborts with no commit
    tick();
    issue(MULTU, 32'd3, 32'd4);
    repeat (33) tick();
    check("fixrst_busy", busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("fixrst_done", done, 0);
    check("fixrst_hi", hi, 0);
    check("fixrst_lo", lo, 0);
    watch_no_done(40, saw_done);
    check("fixrst_no_done", saw_done, 0);

    // start and MTHI while busy are ignored; reset mid-CALC aborts
    hi_we = 1'b1; wdata = 32'h77; tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h88; tick();
    lo_we = 1'b0;
    issue(MULTU, 32'd5, 32'd6);
    repeat (9) tick();
    op = DIVU; A = 32'd1; B = 32'd0; start = 1'b1;
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    tick();
    start = 1'b0; hi_we = 1'b0;
    check("busy_hi_we", hi, 32'h77);
    check("busy_still", busy, 1);
    check("busy_dz", DZ, 0);
    watch_no_done(10, saw_done);
    check("busy_no_done", saw_done, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("calcrst_hi", hi, 0);
    check("calcrst_lo", lo, 0);
    check("calcrst_busy", busy, 0);
    check("calcrst_done", done, 0);
    check("calcrst_dz", DZ, 0);
    check("calcrst_of", OF, 0);
    watch_no_done(40, saw_done);
    check("calcrst_no_done", saw_done, 0);

    // start coincident with reset is ignored
    op = MULTU; A = 32'd1; B = 32'd1; start = 1'b1; rst = 1'b1;
    tick();
    start = 1'b0; rst = 1'b0;
    check("rststart_busy", busy, 0);
    tick();
    check("rststart_busy2", busy, 0);
    check("rststart_done", done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
